// File: rtl/hawk_axi_line_master_if.sv
// rtl/hawk_axi_line_master_if.sv - AXI4 write (AW/W/B) and read (AR/R) bus bundles for 256-bit line traffic
//
// HACD_MC_AXI_WR_BUS : AW address channel, W data channel (256-bit beats, 32 strobes), B response channel.
// HACD_MC_AXI_RD_BUS : AR address channel, R data channel (256-bit beats).
// Modports: mst (drives requests, consumes responses), slv (the mirror image).

interface HACD_MC_AXI_WR_BUS;
    logic [5:0]   awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [5:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    modport mst (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slv (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

interface HACD_MC_AXI_RD_BUS;
    logic [5:0]   arid;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [5:0]   rid;
    logic [255:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    modport mst (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slv (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/hawk_axi_line_master.sv
// rtl/hawk_axi_line_master.sv - single-outstanding 64-byte cache-line master onto AXI4 (two 32-byte beats)
//
// Parameter TXN_ID : AXI ID used on awid/arid and expected back on bid.
// clk, rst_n       : rising-edge clock, asynchronous active-low reset.
// req_*            : line request (valid/ready handshake, wr flag, 64-bit byte address,
//                    512-bit data and 64-bit strobes split into two 256-bit beats).
// rsp_*            : one-cycle completion pulse with read line and error flag.
// wr_bus           : AXI4 AW/W/B master side.
// rd_bus           : AXI4 AR/R master side.
//
// Every AXI output is decoded from registered state only, so no AXI input can
// reach an AXI output within a cycle.

module hawk_axi_line_master #(
    parameter logic [5:0] TXN_ID = 6'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [63:0]          req_addr,
    input  logic [511:0]         req_wdata,
    input  logic [63:0]          req_wstrb,
    output logic                 rsp_valid,
    output logic [511:0]         rsp_rdata,
    output logic                 rsp_err,
    HACD_MC_AXI_WR_BUS.mst       wr_bus,
    HACD_MC_AXI_RD_BUS.mst       rd_bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [57:0]    line_q;
    logic [511:0]   wdata_q;
    logic [63:0]    wstrb_q;
    logic           aw_done_q;
    logic           w_done_q;
    logic           wbeat_q;
    logic           rbeat_q;
    // Holds req_ready low through reset and the first edge after it.
    logic           armed_q;

    logic           accept;
    logic           aw_hs;
    logic           w_hs;
    logic           r_hs;
    logic           wr_exit;
    logic           r_bad;

    // Line offset bits and the returned read ID carry no meaning here.
    logic           unused_inputs;
    assign unused_inputs = ^{req_addr[5:0], rd_bus.rid};

    assign accept = req_valid & req_ready;
    assign aw_hs  = wr_bus.awvalid & wr_bus.awready;
    assign w_hs   = wr_bus.wvalid & wr_bus.wready;
    assign r_hs   = rd_bus.rvalid & rd_bus.rready;

    // AW and W complete independently; leave WR once both are finished,
    // counting handshakes that land in this very cycle.
    assign wr_exit = (aw_done_q | aw_hs) & (w_done_q | (w_hs & wbeat_q));

    // A read beat is bad on a non-OKAY response or a misplaced rlast.
    assign r_bad = (rd_bus.rresp != 2'b00) | (rbeat_q ? ~rd_bus.rlast : rd_bus.rlast);

    // Fixed burst shape: 2 beats of 32 bytes, INCR, line-aligned.
    assign wr_bus.awid    = TXN_ID;
    assign wr_bus.awaddr  = {line_q, 6'b0};
    assign wr_bus.awlen   = 8'd1;
    assign wr_bus.awsize  = 3'b101;
    assign wr_bus.awburst = 2'b01;
    assign rd_bus.arid    = TXN_ID;
    assign rd_bus.araddr  = {line_q, 6'b0};
    assign rd_bus.arlen   = 8'd1;
    assign rd_bus.arsize  = 3'b101;
    assign rd_bus.arburst = 2'b01;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        wr_bus.awvalid = 1'b0;
        wr_bus.wvalid  = 1'b0;
        wr_bus.wlast   = 1'b0;
        wr_bus.wdata   = wbeat_q ? wdata_q[511:256] : wdata_q[255:0];
        wr_bus.wstrb   = wbeat_q ? wstrb_q[63:32] : wstrb_q[31:0];
        wr_bus.bready  = 1'b0;
        rd_bus.arvalid = 1'b0;
        rd_bus.rready  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = armed_q;
                if (accept) begin
                    state_d = req_wr ? WR : RD_ADDR;
                end
            end
            WR: begin
                wr_bus.awvalid = ~aw_done_q;
                wr_bus.wvalid  = ~w_done_q;
                wr_bus.wlast   = wbeat_q & ~w_done_q;
                if (wr_exit) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                wr_bus.bready = 1'b1;
                if (wr_bus.bvalid) begin
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                rd_bus.arvalid = 1'b1;
                if (rd_bus.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                rd_bus.rready = 1'b1;
                if (rd_bus.rvalid && rbeat_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q   <= 1'b0;
            line_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wbeat_q   <= 1'b0;
            rbeat_q   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        line_q    <= req_addr[63:6];
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        wbeat_q   <= 1'b0;
                        rbeat_q   <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                WR: begin
                    if (wr_exit) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        wbeat_q   <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_done_q <= 1'b1;
                        end
                        if (w_hs) begin
                            if (wbeat_q) begin
                                w_done_q <= 1'b1;
                            end else begin
                                wbeat_q <= 1'b1;
                            end
                        end
                    end
                end
                WR_RESP: begin
                    if (wr_bus.bvalid) begin
                        rsp_err <= (wr_bus.bresp != 2'b00) | (wr_bus.bid != TXN_ID);
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        if (rbeat_q) begin
                            rsp_rdata[511:256] <= rd_bus.rdata;
                        end else begin
                            rsp_rdata[255:0] <= rd_bus.rdata;
                        end
                        // Error is sticky across both beats of the burst.
                        rsp_err <= rsp_err | r_bad;
                        rbeat_q <= ~rbeat_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/hawk_axi_line_master.md
HAWK_AXI_LINE_MASTER -- requirements
Module: hawk_axi_line_master

Interface
REQ-001 Parameter: TXN_ID, 6'd0, AXI ID driven on awid/arid for every transaction.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  cache-line request present.
REQ-005 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-006 req_wr  in  1  1 = write line, 0 = read line.
REQ-007 req_addr  in  64  byte address; bits [5:0] ignored.
REQ-008 req_wdata  in  512  line data; beat 0 = [255:0], beat 1 = [511:256].
REQ-009 req_wstrb  in  64  byte strobes; beat 0 = [31:0], beat 1 = [63:32].
REQ-010 rsp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-011 rsp_rdata  out  512  read line, valid with rsp_valid on reads; 0 on writes.
REQ-012 rsp_err  out  1  completion error flag, valid with rsp_valid.
REQ-013 wr_bus  HACD_MC_AXI_WR_BUS.mst  --  AXI4 AW/W/B channels.
REQ-014 rd_bus  HACD_MC_AXI_RD_BUS.mst  --  AXI4 AR/R channels.

Function
REQ-015 FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE; one transaction outstanding at most.
REQ-016 req_ready SHALL be 1 only in IDLE; accepted fields registered at acceptance; inputs then ignored until return to IDLE.
REQ-017 Fixed attributes: awlen/arlen = 8'd1 (2 beats), awsize/arsize = 3'b101 (32 B), awburst/arburst = 2'b01 (INCR), awaddr/araddr = {addr[63:6], 6'b0}.
REQ-018 IDLE + accepted write -> WR next cycle: awvalid=1 and wvalid=1 with beat 0 asserted in the same cycle; wvalid never precedes awvalid.
REQ-019 awvalid SHALL hold until awready sampled high, then drop; awaddr stable while awvalid.
REQ-020 W beats: wvalid held with stable wdata/wstrb until wready; beat 0 wlast=0, beat 1 wlast=1; beat counter advances on wvalid & wready.
REQ-021 W beats proceed independently of AW completion; WR exits to WR_RESP only when AW handshake done and beat 1 accepted (either order, same cycle allowed).
REQ-022 WR_RESP: bready=1; on bvalid: rsp_err = (bresp != 0) | (bid != TXN_ID) -> DONE.
REQ-023 IDLE + accepted read -> RD_ADDR: arvalid=1 held until arready, then RD_DATA.
REQ-024 RD_DATA: rready=1; beat k (k=0,1) captured into rsp_rdata[256k+255:256k] on rvalid & rready.
REQ-025 Read error sticky over the burst: any rresp != 0, rlast=1 on beat 0, or rlast=0 on beat 1 sets rsp_err; exit to DONE after beat 1 regardless.
REQ-026 DONE: rsp_valid=1 for exactly one cycle -> IDLE; req_ready may assert the following cycle (min. 1 idle cycle between transactions).
REQ-027 All-zero strobe writes SHALL still issue full AW/W/B handshakes.
REQ-028 bvalid, or rvalid outside RD_DATA, SHALL be ignored (bready/rready low); no state change.
REQ-029 No combinational path from any AXI input to any AXI output.

Reset
REQ-030 On rst_n low, immediately: FSM=IDLE; awvalid, wvalid, wlast, bready, arvalid, rready, req_ready, rsp_valid, rsp_err = 0; rsp_rdata = 0; beat counters = 0.
REQ-031 Reset mid-transaction aborts it with no rsp_valid; req_ready=1 on first clock edge after rst_n deasserts.

Verification
REQ-032 Write addr 0x1234_5678_9AC0, strb all-ones, awready/wready/bvalid always high -> awaddr 0x1234_5678_9AC0, 2 W beats, wlast on beat 1, rsp_valid with rsp_err=0.
REQ-033 Write with awready delayed 5 cycles, wready stalled 3 cycles on beat 1 -> data/strb stable during stalls, single bready handshake, rsp_err=0.
REQ-034 Read of line written with 0xA5.. (beat 0) / 0x5A.. (beat 1), rvalid gapped 2 cycles -> rsp_rdata = {256'h5A.., 256'hA5..}, rsp_err=0.
REQ-035 Read with rresp=2'b10 on beat 1 -> rsp_err=1, rsp_valid single pulse; write with bresp=2'b10 -> rsp_err=1.
REQ-036 rst_n pulsed low during WR after beat 0 accepted -> all valids 0 immediately, no rsp_valid, next request completes normally.
REQ-037 Back-to-back write then read on same address with req_valid held -> second accepted only after rsp_valid of first; read returns written data with strobe masks applied.
